sdram_resp: RTL and testbench

SDRAM_RESP -- requirements
Module: sdram_resp

---
 rtl/sdram_resp.sv | 258 +++++++++++++++++++++++++
 tb/tb_sdram_resp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_resp
//  Brief    : Behavioural SDRAM responder. It checks the init sequence and
//             bank timing, stores 16-bit words, returns read data after CAS
//             latency, and flags the first protocol violation it sees.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_resp #(
    parameter int MEM_AW  = 16,
    parameter int T_RCD   = 1,
    parameter int T_RP    = 1,
    parameter int T_RC    = 4,
    parameter int T_WR    = 2,
    parameter int REF_MAX = 600
) (
    input  logic        clk,
    input  logic        resetn,
    inout  wire  [15:0] SDRAM_DQ,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic        SDRAM_CKE,
    input  logic [1:0]  SDRAM_DQM,
    output logic        ready,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [15:0] ref_count
);

    localparam int c_CNT_W = 8;
    localparam int c_WD_W  = $clog2(REF_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_RCD_LD = c_CNT_W'(T_RCD - 1);
    localparam logic [c_CNT_W-1:0] c_RP_LD  = c_CNT_W'(T_RP - 1);
    localparam logic [c_CNT_W-1:0] c_RC_LD  = c_CNT_W'(T_RC - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LD  = c_CNT_W'(T_WR);
    localparam logic [c_WD_W-1:0]  c_WD_MAX = c_WD_W'(REF_MAX);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_REF1  = 3'd1,
        S_REF2  = 3'd2,
        S_WMRS  = 3'd3,
        S_MRSD1 = 3'd4,
        S_MRSD2 = 3'd5,
        S_READY = 3'd6
    } state_t;

    state_t r_state;
    logic   r_cl3;                      // 1: CAS latency 3, 0: CAS latency 2
    logic [c_WD_W-1:0] r_wd;

    logic [3:0]          r_active;
    logic [3:0]          r_ap_pend;
    logic [12:0]         r_row    [4];
    logic [c_CNT_W-1:0]  r_rcd    [4];
    logic [c_CNT_W-1:0]  r_rp     [4];
    logic [c_CNT_W-1:0]  r_rc     [4];
    logic [c_CNT_W-1:0]  r_ap_cnt [4];

    logic [15:0] r_mem [2**MEM_AW];

    // Read pipeline: stage 1 feeds stage 0, stage 0 feeds the output driver
    logic [1:0]  r_p1_oe, r_p0_oe, r_oe;
    logic [15:0] r_p1_d,  r_p0_d,  r_dout;

    // Command decode; a deselected chip or CKE low is a NOP
    logic       w_sel;
    logic [2:0] w_op;
    logic       w_act, w_rd, w_wr, w_ref, w_pre, w_mrs;
    assign w_sel = SDRAM_CKE && !SDRAM_nCS;
    assign w_op  = {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    assign w_act = w_sel && (w_op == 3'b011);
    assign w_rd  = w_sel && (w_op == 3'b101);
    assign w_wr  = w_sel && (w_op == 3'b100);
    assign w_ref = w_sel && (w_op == 3'b001);
    assign w_pre = w_sel && (w_op == 3'b010);
    assign w_mrs = w_sel && (w_op == 3'b000);

    // Init-only commands execute only when they are the step being waited for
    logic w_ref_exec, w_pre_exec, w_mrs_exec, w_mrs_ok, w_ready_st;
    assign w_ready_st = (r_state == S_READY);
    assign w_ref_exec = w_ref && (r_state == S_REF1 || r_state == S_REF2 || w_ready_st);
    assign w_pre_exec = w_pre && ((r_state == S_PWRUP && SDRAM_A[10]) || w_ready_st);
    assign w_mrs_exec = w_mrs && (r_state == S_WMRS);
    assign w_mrs_ok   = (SDRAM_A[6:4] == 3'd2 || SDRAM_A[6:4] == 3'd3) && (SDRAM_A[2:0] == 3'd0);

    logic [MEM_AW-1:0] w_idx;
    assign w_idx = MEM_AW'({SDRAM_BA, r_row[SDRAM_BA], SDRAM_A[8:0]});

    // Any bank still inside its precharge or row-cycle window
    logic w_busy_any;
    always_comb begin
        w_busy_any = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (r_rp[b] != '0 || r_rc[b] != '0) w_busy_any = 1'b1;
        end
    end

    // Violation flags for this edge, resolved lowest code first
    logic [9:1] w_viol;
    logic [3:0] w_code;
    always_comb begin
        w_viol[1] = (w_act || w_rd || w_wr) && !w_ready_st;
        w_viol[2] = w_act && r_active[SDRAM_BA];
        w_viol[3] = (w_rd || w_wr) && !r_active[SDRAM_BA];
        w_viol[4] = (w_rd || w_wr) && (r_rcd[SDRAM_BA] != '0);
        w_viol[5] = (w_act && (r_rp[SDRAM_BA] != '0 || r_rc[SDRAM_BA] != '0))
                  || (w_ref_exec && w_busy_any);
        w_viol[6] = w_ref_exec && (|r_active);
        w_viol[7] = w_mrs_exec && !w_mrs_ok;
        w_viol[8] = w_ready_st && !w_ref_exec && (r_wd == c_WD_MAX);
        w_viol[9] = w_wr && (r_oe != 2'b00);
        if      (w_viol[1]) w_code = 4'd1;
        else if (w_viol[2]) w_code = 4'd2;
        else if (w_viol[3]) w_code = 4'd3;
        else if (w_viol[4]) w_code = 4'd4;
        else if (w_viol[5]) w_code = 4'd5;
        else if (w_viol[6]) w_code = 4'd6;
        else if (w_viol[7]) w_code = 4'd7;
        else if (w_viol[8]) w_code = 4'd8;
        else if (w_viol[9]) w_code = 4'd9;
        else                w_code = 4'd0;
    end

    // Init FSM, CAS latency, refresh counter, watchdog and sticky error
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_PWRUP;
            r_cl3     <= 1'b0;
            r_wd      <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            err_code  <= 4'd0;
            ref_count <= 16'd0;
        end else begin
            if (w_code != 4'd0 && !err) begin
                err      <= 1'b1;
                err_code <= w_code;
            end
            if (w_ref_exec) ref_count <= ref_count + 16'd1;
            if (w_ready_st && !w_ref_exec) begin
                if (r_wd != c_WD_MAX) r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
            case (r_state)
                S_PWRUP: if (w_pre_exec) r_state <= S_REF1;
                S_REF1:  if (w_ref_exec) r_state <= S_REF2;
                S_REF2:  if (w_ref_exec) r_state <= S_WMRS;
                S_WMRS:  if (w_mrs_exec && w_mrs_ok) begin
                             r_cl3   <= (SDRAM_A[6:4] == 3'd3);
                             r_state <= S_MRSD1;
                         end
                S_MRSD1: r_state <= S_MRSD2;
                S_MRSD2: begin
                             r_state <= S_READY;
                             ready   <= 1'b1;
                         end
                S_READY: r_state <= S_READY;
                default: r_state <= S_PWRUP;
            endcase
        end
    end

    // Per-bank open/closed state, open row, timing counters and auto-precharge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_active  <= 4'b0;
            r_ap_pend <= 4'b0;
            for (int b = 0; b < 4; b++) begin
                r_row[b]    <= 13'd0;
                r_rcd[b]    <= '0;
                r_rp[b]     <= '0;
                r_rc[b]     <= '0;
                r_ap_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - 1'b1;
                if (r_rp[b]  != '0) r_rp[b]  <= r_rp[b]  - 1'b1;
                if (r_rc[b]  != '0) r_rc[b]  <= r_rc[b]  - 1'b1;
                if (r_ap_pend[b]) begin
                    if (r_ap_cnt[b] <= c_CNT_W'(1)) begin
                        r_active[b]  <= 1'b0;
                        r_ap_pend[b] <= 1'b0;
                        r_rp[b]      <= c_RP_LD;
                    end else begin
                        r_ap_cnt[b] <= r_ap_cnt[b] - 1'b1;
                    end
                end
                if (w_ref_exec) r_rc[b] <= c_RC_LD;
                if (w_pre_exec && (SDRAM_A[10] || SDRAM_BA == 2'(b))) begin
                    r_active[b]  <= 1'b0;
                    r_ap_pend[b] <= 1'b0;
                    r_rp[b]      <= c_RP_LD;
                end
                if (w_act && SDRAM_BA == 2'(b)) begin
                    r_active[b]  <= 1'b1;
                    r_ap_pend[b] <= 1'b0;
                    r_row[b]     <= SDRAM_A;
                    r_rcd[b]     <= c_RCD_LD;
                    r_rc[b]      <= c_RC_LD;
                end
                if ((w_rd || w_wr) && SDRAM_A[10] && SDRAM_BA == 2'(b)) begin
                    r_ap_pend[b] <= 1'b1;
                    r_ap_cnt[b]  <= w_rd ? (r_cl3 ? c_CNT_W'(3) : c_CNT_W'(2)) : c_WR_LD;
                end
            end
        end
    end

    // Storage write with per-byte masking; contents survive reset
    always_ff @(posedge clk) begin
        if (resetn && w_wr) begin
            if (!SDRAM_DQM[0]) r_mem[w_idx][7:0]  <= SDRAM_DQ[7:0];
            if (!SDRAM_DQM[1]) r_mem[w_idx][15:8] <= SDRAM_DQ[15:8];
        end
    end

    // CAS-latency read pipeline: a READ enters the stage that is CL-2 away from the driver
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_p1_oe <= 2'b00;
            r_p1_d  <= 16'd0;
            r_p0_oe <= 2'b00;
            r_p0_d  <= 16'd0;
            r_oe    <= 2'b00;
            r_dout  <= 16'd0;
        end else begin
            r_oe    <= r_p0_oe;
            r_dout  <= r_p0_d;
            r_p0_oe <= r_p1_oe;
            r_p0_d  <= r_p1_d;
            r_p1_oe <= 2'b00;
            r_p1_d  <= 16'd0;
            if (w_rd) begin
                if (r_cl3) begin
                    r_p1_oe <= ~SDRAM_DQM;
                    r_p1_d  <= r_mem[w_idx];
                end else begin
                    r_p0_oe <= ~SDRAM_DQM;
                    r_p0_d  <= r_mem[w_idx];
                end
            end
        end
    end

    // Byte-lane drivers; reset releases the bus without waiting for a clock edge
    for (genvar g = 0; g < 2; g++) begin : g_dq_byte
        assign SDRAM_DQ[8*g +: 8] = (resetn && r_oe[g]) ? r_dout[8*g +: 8] : 8'bzzzz_zzzz;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_resp
//  Brief    : Directed bench for sdram_resp. The DQ net is pulled high, so a
//             byte lane that nobody drives reads back as 8'hFF.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_resp;

    localparam logic [2:0] OP_ACT = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_MRS = 3'b000;

    logic        clk;
    logic        resetn;
    logic [12:0] a;
    logic [1:0]  ba;
    logic        ncs, nras, ncas, nwe, cke;
    logic [1:0]  dqm;
    logic [15:0] dq_drv;
    logic        dq_en;
    tri1  [15:0] dq;
    logic        ready, err;
    logic [3:0]  err_code;
    logic [15:0] ref_count;

    int n_checks = 0;
    int n_fail   = 0;

    assign dq = dq_en ? dq_drv : 16'hzzzz;

    sdram_resp #(.T_RCD(2)) dut (
        .clk(clk), .resetn(resetn), .SDRAM_DQ(dq), .SDRAM_A(a), .SDRAM_BA(ba),
        .SDRAM_nCS(ncs), .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe),
        .SDRAM_CKE(cke), .SDRAM_DQM(dqm), .ready(ready), .err(err),
        .err_code(err_code), .ref_count(ref_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command for one rising edge, then return to NOP at the next falling edge
    task automatic cmd(input logic [2:0] op, input logic [1:0] b, input logic [12:0] addr,
                       input logic [1:0] m, input logic drive, input logic [15:0] d);
        ncs = 1'b0; {nras, ncas, nwe} = op; ba = b; a = addr; dqm = m;
        dq_en = drive; dq_drv = d;
        @(negedge clk);
        ncs = 1'b1; {nras, ncas, nwe} = 3'b111; dqm = 2'b00; dq_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    task automatic do_init();
        do_reset();
        cmd(OP_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(3);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        cmd(OP_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0);
        idle(2);
    endtask

    task automatic test_reset();
        do_init();
        cmd(OP_RD, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd3) begin n_fail++; $display("FAIL rd_idle_code: got %0d expected 3", err_code); end
        resetn = 1'b0;
        idle(1);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (err_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", err_code); end
        n_checks++; if (ref_count !== 16'd0) begin n_fail++; $display("FAIL reset_refcnt: got %0d expected 0", ref_count); end
        n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dq: got %h expected ffff", dq); end
    endtask

    task automatic test_init();
        do_reset();
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        n_checks++; if (ref_count !== 16'd0) begin n_fail++; $display("FAIL init_ref_ignored: got %0d expected 0", ref_count); end
        cmd(OP_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(3);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        cmd(OP_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_mrs0: got %b expected 0", ready); end
        idle(1);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_mrs1: got %b expected 0", ready); end
        idle(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_mrs2: got %b expected 1", ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %b expected 0", err); end
        n_checks++; if (ref_count !== 16'd2) begin n_fail++; $display("FAIL init_refcnt: got %0d expected 2", ref_count); end
    endtask

    task automatic test_bad_mrs_cl3();
        do_reset();
        cmd(OP_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(3);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        cmd(OP_MRS, 2'd0, 13'h050, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd7) begin n_fail++; $display("FAIL bad_mrs_code: got %0d expected 7", err_code); end
        idle(3);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bad_mrs_ready: got %b expected 0", ready); end
        cmd(OP_MRS, 2'd0, 13'h030, 2'b00, 1'b0, 16'h0);
        idle(2);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL cl3_ready: got %b expected 1", ready); end
        cmd(OP_ACT, 2'd1, 13'h007, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_WR, 2'd1, 13'h009, 2'b00, 1'b1, 16'h5AA5);
        cmd(OP_RD, 2'd1, 13'h009, 2'b00, 1'b0, 16'h0);
        idle(1);
        n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL cl3_early: got %h expected ffff", dq); end
        idle(1);
        n_checks++; if (dq !== 16'h5AA5) begin n_fail++; $display("FAIL cl3_data: got %h expected 5aa5", dq); end
    endtask

    task automatic test_write_read();
        do_init();
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_WR, 2'd0, 13'h403, 2'b00, 1'b1, 16'hA55A);
        idle(2);
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd0, 13'h403, 2'b00, 1'b0, 16'h0);
        n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL rd_before: got %h expected ffff", dq); end
        idle(1);
        n_checks++; if (dq !== 16'hA55A) begin n_fail++; $display("FAIL rd_data: got %h expected a55a", dq); end
        idle(1);
        n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL rd_after: got %h expected ffff", dq); end
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ap_bank_idle_err: got %b code %0d expected 0", err, err_code); end
        n_checks++; if (ref_count !== 16'd3) begin n_fail++; $display("FAIL ap_refcnt: got %0d expected 3", ref_count); end
    endtask

    task automatic test_mask();
        do_init();
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_WR, 2'd0, 13'h403, 2'b10, 1'b1, 16'h1234);
        idle(2);
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd0, 13'h403, 2'b00, 1'b0, 16'h0);
        idle(1);
        n_checks++; if (dq !== 16'hA534) begin n_fail++; $display("FAIL mask_write: got %h expected a534", dq); end
        idle(1);
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd0, 13'h403, 2'b01, 1'b0, 16'h0);
        idle(1);
        n_checks++; if (dq !== 16'hA5FF) begin n_fail++; $display("FAIL mask_read: got %h expected a5ff", dq); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mask_err: got %b code %0d expected 0", err, err_code); end
    endtask

    task automatic test_trcd();
        do_init();
        cmd(OP_ACT, 2'd0, 13'h001, 2'b00, 1'b0, 16'h0);
        cmd(OP_RD, 2'd0, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd4) begin n_fail++; $display("FAIL trcd_code: got err %b code %0d expected 1/4", err, err_code); end
        cmd(OP_ACT, 2'd0, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd4) begin n_fail++; $display("FAIL first_code_held: got %0d expected 4", err_code); end
    endtask

    task automatic test_act_codes();
        do_init();
        cmd(OP_ACT, 2'd1, 13'h001, 2'b00, 1'b0, 16'h0);
        idle(3);
        cmd(OP_ACT, 2'd1, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd2) begin n_fail++; $display("FAIL act_open_code: got %0d expected 2", err_code); end
        do_init();
        cmd(OP_ACT, 2'd2, 13'h001, 2'b00, 1'b0, 16'h0);
        cmd(OP_PRE, 2'd2, 13'h000, 2'b00, 1'b0, 16'h0);
        cmd(OP_ACT, 2'd2, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd5) begin n_fail++; $display("FAIL act_trc_code: got %0d expected 5", err_code); end
    endtask

    task automatic test_pre_init_and_ref_active();
        do_reset();
        cmd(OP_RD, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd1) begin n_fail++; $display("FAIL pre_init_code: got err %b code %0d expected 1/1", err, err_code); end
        do_init();
        cmd(OP_ACT, 2'd0, 13'h001, 2'b00, 1'b0, 16'h0);
        idle(3);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd6) begin n_fail++; $display("FAIL ref_active_code: got %0d expected 6", err_code); end
        n_checks++; if (ref_count !== 16'd3) begin n_fail++; $display("FAIL ref_active_cnt: got %0d expected 3", ref_count); end
    endtask

    task automatic test_dq_conflict();
        do_init();
        cmd(OP_ACT, 2'd3, 13'h002, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd3, 13'h000, 2'b00, 1'b0, 16'h0);
        cmd(OP_WR, 2'd3, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_before_drive: got err %b code %0d expected 0", err, err_code); end
        cmd(OP_WR, 2'd3, 13'h001, 2'b00, 1'b0, 16'h0);
        n_checks++; if (err_code !== 4'd9) begin n_fail++; $display("FAIL wr_during_drive: got %0d expected 9", err_code); end
    endtask

    task automatic test_watchdog();
        do_init();
        idle(580);
        cmd(OP_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(600);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wd_600: got err %b code %0d expected 0", err, err_code); end
        idle(1);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd8) begin n_fail++; $display("FAIL wd_601: got err %b code %0d expected 1/8", err, err_code); end
    endtask

    task automatic test_reset_midread();
        do_init();
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_WR, 2'd0, 13'h403, 2'b00, 1'b1, 16'hBEEF);
        idle(2);
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd0, 13'h003, 2'b00, 1'b0, 16'h0);
        idle(1);
        n_checks++; if (dq !== 16'hBEEF) begin n_fail++; $display("FAIL midread_data: got %h expected beef", dq); end
        resetn = 1'b0;
        #1;
        n_checks++; if (dq !== 16'hFFFF) begin n_fail++; $display("FAIL midread_release: got %h expected ffff", dq); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midread_ready: got %b expected 0", ready); end
        do_init();
        cmd(OP_ACT, 2'd0, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        cmd(OP_RD, 2'd0, 13'h403, 2'b00, 1'b0, 16'h0);
        idle(1);
        n_checks++; if (dq !== 16'hBEEF) begin n_fail++; $display("FAIL retained_data: got %h expected beef", dq); end
    endtask

    initial begin
        resetn = 1'b0; ncs = 1'b1; nras = 1'b1; ncas = 1'b1; nwe = 1'b1; cke = 1'b1;
        a = 13'd0; ba = 2'd0; dqm = 2'b00; dq_drv = 16'h0; dq_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_init();
        test_bad_mrs_cl3();
        test_write_read();
        test_mask();
        test_trcd();
        test_act_codes();
        test_pre_init_and_ref_active();
        test_dq_conflict();
        test_watchdog();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
